// File: rtl/fb_fill_if.sv
// fb_fill_if: command handshake and framebuffer write port of the fill engine
interface fb_fill_if #(parameter int ADDR_W = 16);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [7:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [2:0]        cmd_color;
    logic              busy;
    logic              done;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_waddr;
    logic [2:0]        fb_wdata;
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, busy, done, fb_we, fb_waddr, fb_wdata
    );
    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, busy, done, fb_we, fb_waddr, fb_wdata
    );
endinterface

// File: rtl/fb_fill.sv
// fb_fill: clipped rectangle fill engine writing one framebuffer pixel per clock
module fb_fill #(
    parameter int FB_WIDTH  = 214,
    parameter int FB_HEIGHT = 160,
    parameter int ADDR_W    = 16
) (
    input logic      clk,
    input logic      rst_async,
    fb_fill_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
    state_t            state_q, state_d;
    logic [7:0]        x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [7:0]        col_q, col_d, line_q, line_d;
    logic [2:0]        color_q, color_d, fb_wdata_q, fb_wdata_d;
    logic [8:0]        x_end_q, x_end_d, y_end_q, y_end_d, x_sum, y_sum;
    logic [ADDR_W-1:0] row_base_q, row_base_d, fb_waddr_q, fb_waddr_d;
    logic              cmd_ready_q, cmd_ready_d, busy_q, busy_d, done_q, done_d, fb_we_q, fb_we_d;
    logic              empty, last_col, last_line;

    always_comb begin
        x_sum      = {1'b0, x_q} + {1'b0, w_q};
        y_sum      = {1'b0, y_q} + {1'b0, h_q};
        empty      = w_q == 8'd0 || h_q == 8'd0 || {1'b0, x_q} >= 9'(FB_WIDTH) || {1'b0, y_q} >= 9'(FB_HEIGHT);
        last_col   = {1'b0, col_q} == x_end_q - 9'd1;
        last_line  = {1'b0, line_q} == y_end_q - 9'd1;
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        col_d      = col_q;
        line_d     = line_q;
        row_base_d = row_base_q;
        case (state_q)
            IDLE: if (bus.cmd_valid && cmd_ready_q) begin
                x_d     = bus.cmd_x;
                y_d     = bus.cmd_y;
                w_d     = bus.cmd_w;
                h_d     = bus.cmd_h;
                color_d = bus.cmd_color;
                state_d = SETUP;
            end
            SETUP: begin
                x_end_d    = x_sum > 9'(FB_WIDTH) ? 9'(FB_WIDTH) : x_sum;
                y_end_d    = y_sum > 9'(FB_HEIGHT) ? 9'(FB_HEIGHT) : y_sum;
                col_d      = x_q;
                line_d     = y_q;
                row_base_d = ADDR_W'(y_q) * ADDR_W'(FB_WIDTH);
                state_d    = empty ? DONE : FILL;
            end
            // col/line/row_base track the pixel currently presented on the write port
            FILL: begin
                col_d      = last_col ? x_q : col_q + 8'd1;
                line_d     = last_col ? line_q + 8'd1 : line_q;
                row_base_d = last_col ? row_base_q + ADDR_W'(FB_WIDTH) : row_base_q;
                state_d    = last_col && last_line ? DONE : FILL;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = state_d == IDLE;
        busy_d      = state_d != IDLE;
        done_d      = state_d == DONE;
        fb_we_d     = state_d == FILL;
        fb_waddr_d  = fb_we_d ? row_base_d + ADDR_W'(col_d) : fb_waddr_q;
        fb_wdata_d  = fb_we_d ? color_q : fb_wdata_q;
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            col_q       <= '0;
            line_q      <= '0;
            row_base_q  <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_waddr_q  <= '0;
            fb_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            x_end_q     <= x_end_d;
            y_end_q     <= y_end_d;
            col_q       <= col_d;
            line_q      <= line_d;
            row_base_q  <= row_base_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fb_we_q     <= fb_we_d;
            fb_waddr_q  <= fb_waddr_d;
            fb_wdata_q  <= fb_wdata_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fb_we     = fb_we_q;
    assign bus.fb_waddr  = fb_waddr_q;
    assign bus.fb_wdata  = fb_wdata_q;
endmodule

// File: doc/fb_fill.md
# fb_fill

Rectangle fill engine that sits directly upstream of the framebuffer RAM read by the VGA output stage. It accepts a rectangle command (origin, size, 3-bit colour) over a valid/ready handshake and writes one framebuffer pixel per clock through the RAM's write port. It is used to clear the screen and to draw solid boxes without CPU per-pixel stores. Rectangles are clipped to the 214x160 framebuffer, and addresses use the same row-major layout the display stage scans: addr = y*214 + x.

## Interface
- FB_WIDTH, 214, framebuffer pixels per line
- FB_HEIGHT, 160, framebuffer lines
- ADDR_W, 16, framebuffer address width
- clk  in  1  system clock (50 MHz)
- rst_async  in  1  asynchronous, active-low reset (0 = reset asserted)
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x  in  8  left column
- cmd_y  in  8  top line
- cmd_w  in  8  width in pixels
- cmd_h  in  8  height in lines
- cmd_color  in  3  pixel value {b,g,r}
- busy  out  1  command in progress (state != IDLE)
- done  out  1  one-cycle pulse when a command completes
- fb_we  out  1  framebuffer write enable
- fb_waddr  out  ADDR_W  framebuffer write address
- fb_wdata  out  3  framebuffer write data

## Operation
- States: IDLE, SETUP, FILL, DONE.
- **IDLE:** cmd_ready=1. On cmd_valid & cmd_ready, latch all cmd_* fields and go to SETUP.
- **SETUP (1 cycle):** clip the rectangle.
  - x_end = min(x+w, FB_WIDTH) and y_end = min(y+h, FB_HEIGHT). Sums are 9-bit, so no wrap.
  - If w==0, h==0, x>=FB_WIDTH or y>=FB_HEIGHT, the rectangle is empty: go to DONE.
  - Otherwise set row_base = y*FB_WIDTH (16-bit, maximum 34026) and col = x, then go to FILL.
- **FILL:** every cycle, issue fb_we=1, fb_waddr=row_base+col, fb_wdata=color.
  - If col==x_end-1: set col=x and row_base+=FB_WIDTH. If that was the last line (line==y_end-1), go to DONE.
  - Otherwise col+=1.
  - Writes go in row-major order, left to right and top to bottom.
- **DONE (1 cycle):** done=1, then go to IDLE.
- cmd_valid is ignored outside IDLE. Commands are never queued.
- cmd_* inputs may change freely after acceptance.
- fb_waddr and fb_wdata are registered. When fb_we=0 they hold their last values.

## Timing
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, fb_we=0, fb_waddr=0, fb_wdata=0.
- Reset asserted mid-command aborts immediately. No further fb_we after the asynchronous assertion, and no done pulse.
- Let the acceptance edge be cycle 0 and N = (x_end-x)*(y_end-y).
  - SETUP occurs in cycle 1.
  - The first fb_we=1 occurs in cycle 2.
  - fb_we stays high for exactly N contiguous cycles.
  - done is high in cycle 2+N.
  - cmd_ready returns high in cycle 3+N.
- Empty rectangle: no fb_we; done in cycle 2; cmd_ready in cycle 3.
- There are no stalls. The framebuffer write port must accept a write every cycle.
- Throughput: one command per N+3 cycles. A back-to-back cmd_valid is accepted in the first IDLE cycle.

## Test plan
- **Full clear:** x=0, y=0, w=214, h=160, color=0 -> 34240 writes to addresses 0..34239 in order; done at cycle 34242; cmd_ready at cycle 34243.
- **Small box:** x=10, y=5, w=3, h=2, color=5 -> fb_waddr 1080, 1081, 1082, 1294, 1295, 1296 in cycles 2-7 with fb_wdata=5; done at cycle 8.
- **Clipping:** x=212, y=159, w=10, h=10 -> exactly two writes, 34238 and 34239; done at cycle 4.
- **Empty commands:**
  - w=0 -> no fb_we; done at cycle 2.
  - x=214, w=5, h=5 -> no fb_we; done at cycle 2.
- **Handshake:** hold cmd_valid high with command B during command A -> cmd_ready=0 and busy=1 throughout A; B is accepted in the cycle after A's done; B's writes are never interleaved with A's.
- **Reset mid-fill:** drive rst_async=0 during the 3rd write of a 100-pixel fill, then release -> fb_we=0 immediately; no done pulse; all outputs at reset values; cmd_ready=1; a new command then executes normally.
